icemem_button_capture: RTL and testbench
========================================

ICEMEM_BUTTON_CAPTURE -- requirements
Module: iomem_button_capture

Interface
REQ-001 SHALL have parameter NBTN, default 4, number of button inputs (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 12000, stable-input cycles needed to accept a change (1 ms at 12 MHz; range 2..65535).
REQ-003 SHALL have parameter BASE_SEL, default 8'h08, value of iomem_addr[31:24] that selects this block.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 btn_n  in  NBTN  raw asynchronous button pins; low = pressed.
REQ-008 iomem_valid  in  1  bus request from picosoc.
REQ-009 iomem_ready  out  1  one-cycle completion pulse.
REQ-010 iomem_wstrb  in  4  byte write strobes; all zero = read.
REQ-011 iomem_addr  in  32  byte address.
REQ-012 iomem_wdata  in  32  write data.
REQ-013 iomem_rdata  out  32  read data, valid while iomem_ready is high.
REQ-014 btn_state  out  NBTN  debounced pressed state (1 = pressed).
REQ-015 irq  out  1  level interrupt to picosoc irq_5..irq_7.

Function
REQ-016 Each btn_n bit SHALL pass through a 2-flop synchronizer, then be inverted to pressed polarity.
REQ-017 Per button: while synchronized value equals btn_state, the 16-bit counter SHALL be 0; while it differs, the counter SHALL increment each cycle.
REQ-018 When the counter reaches DEBOUNCE_CYCLES-1 while differing, btn_state SHALL take the synchronized value on the next edge and the counter SHALL return to 0; a glitch shorter than that resets the counter with no state change.
REQ-019 Latency pin-to-btn_state for a clean edge SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-020 A 0->1 btn_state transition SHALL set PRESS[i]; 1->0 SHALL set RELEASE[i]; both sticky.
REQ-021 Register map (addr[7:0]): 0x00 STATE RO = btn_state; 0x04 PRESS W1C; 0x08 RELEASE W1C; 0x0C IRQ_EN RW, bits [NBTN-1:0] press enable, bits [NBTN+7:8] release enable; 0x10 PRESS_CNT RO, 16-bit wrapping count of all press events, cleared by any write.
REQ-022 Bus handshake: when iomem_valid, !iomem_ready and addr[31:24]==BASE_SEL, iomem_ready SHALL pulse high for exactly one cycle on the next edge, with iomem_rdata and write effects applied on that edge.
REQ-023 Unselected top byte: iomem_ready SHALL stay 0 and no state SHALL change.
REQ-024 Selected but unmapped offset: ready SHALL pulse, rdata SHALL be 0, writes ignored.
REQ-025 Writes SHALL honour only iomem_wstrb[0] (bits 7:0) and wstrb[1] (bits 15:8); unused rdata bits SHALL read 0.
REQ-026 Reads return register values before the same-cycle update.
REQ-027 Event set and W1C clear of the same bit in one cycle: set SHALL win.
REQ-028 PRESS_CNT SHALL wrap 0xFFFF->0x0000; write and press in the same cycle SHALL yield 0.
REQ-029 irq SHALL be registered: irq = |(PRESS & IRQ_EN[NBTN-1:0]) | |(RELEASE & IRQ_EN[NBTN+7:8]), one cycle after the flags.

Reset
REQ-030 On reset: synchronizers SHALL load 0 (released), counters 0, btn_state 0, PRESS 0, RELEASE 0, IRQ_EN 0, PRESS_CNT 0, iomem_ready 0, iomem_rdata 0, irq 0.
REQ-031 Reset asserted mid-debounce or mid-transaction SHALL abort it; no event SHALL be logged for a button held through reset until it is released and pressed again.

Structure
REQ-032 Shared package SHALL hold register offsets (0x00..0x10), BASE_SEL default and counter width 16.
REQ-033 One sub-module, btn_debounce (synchronizer + counter + stable bit, one instance per button), SHALL be used.

Verification
REQ-034 DEBOUNCE_CYCLES=8: btn_n[0] high->low held 20 cycles -> btn_state[0]=1 exactly 10 cycles after the edge, PRESS=0x1, PRESS_CNT=1.
REQ-035 btn_n[1] 5-cycle low glitch, DEBOUNCE_CYCLES=8 -> btn_state, PRESS, RELEASE unchanged.
REQ-036 IRQ_EN write 0x0001, press button 0 -> irq=1 one cycle after PRESS[0]; write PRESS 0x1 -> irq=0 next cycle.
REQ-037 Read 0x08000014 -> one ready pulse, rdata 0; read 0x03000000 -> no ready for 10 cycles.
REQ-038 W1C PRESS[2] in the same cycle button 2 debounces pressed -> PRESS[2] remains 1, PRESS_CNT increments.
REQ-039 reset asserted at counter=5 with button held -> all outputs 0, no event logged after reset while held.

Source files
------------

// File: rtl/icemem_button_capture_pkg.sv
// Shared definitions for the button capture block.
//   - register offsets (addr[7:0]) of the memory-mapped register file
//   - default value of addr[31:24] that selects the block
//   - debounce / press counter width
//   - popcount helper used to count simultaneous press events
package icemem_button_capture_pkg;

    localparam int         CNT_W            = 16;
    localparam logic [7:0] BASE_SEL_DEFAULT = 8'h08;

    localparam logic [7:0] ADDR_STATE     = 8'h00;
    localparam logic [7:0] ADDR_PRESS     = 8'h04;
    localparam logic [7:0] ADDR_RELEASE   = 8'h08;
    localparam logic [7:0] ADDR_IRQ_EN    = 8'h0C;
    localparam logic [7:0] ADDR_PRESS_CNT = 8'h10;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/icemem_button_capture_if.sv
// picosoc iomem bus bundle.
//   iomem_valid  master->slave  request
//   iomem_ready  slave->master  one-cycle completion pulse
//   iomem_wstrb  master->slave  byte strobes, all zero = read
//   iomem_addr   master->slave  byte address
//   iomem_wdata  master->slave  write data
//   iomem_rdata  slave->master  read data, valid while iomem_ready is high
interface icemem_button_capture_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/icemem_button_capture_btn_debounce.sv
// Single-button debouncer: 2-flop synchronizer, 16-bit stability counter and
// the accepted (debounced) pressed state.
//   clk, reset     clock and synchronous active-high reset
//   btn_n          raw asynchronous pin, low = pressed
//   state          debounced pressed state (1 = pressed)
//   press_pulse    high in the cycle whose edge takes state 0->1
//   release_pulse  high in the cycle whose edge takes state 1->0
module btn_debounce
    import icemem_button_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The pin is inverted on the way into the first flop so the synchronizer
    // holds pressed polarity and its reset value 0 means "released".
    logic             sync1_reg;
    logic             sync2_reg;
    // warm_reg fills with ones after reset; once warm_reg[1] is set, sync2_reg
    // holds a real pin sample rather than the reset value.
    logic [1:0]       warm_reg;
    // A button is only debounced once it has been seen released after reset,
    // so a button held through reset produces no press event.
    logic             armed_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             state_reg;
    logic             state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            warm_reg  <= 2'b00;
            armed_reg <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= 1'b0;
        end else begin
            sync1_reg <= ~btn_n;
            sync2_reg <= sync1_reg;
            warm_reg  <= {warm_reg[0], 1'b1};
            if (warm_reg[1] && !sync2_reg) begin
                armed_reg <= 1'b1;
            end
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        cnt_next      = cnt_reg;
        state_next    = state_reg;
        press_pulse   = 1'b0;
        release_pulse = 1'b0;
        if (!armed_reg) begin
            cnt_next   = '0;
            state_next = 1'b0;
        end else if (sync2_reg == state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == LIMIT) begin
            cnt_next      = '0;
            state_next    = sync2_reg;
            press_pulse   = sync2_reg;
            release_pulse = ~sync2_reg;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/icemem_button_capture.sv
// Button capture peripheral for picosoc iomem.
// Debounces NBTN active-low buttons, latches sticky press/release flags,
// counts press events and raises a level interrupt.
//   clk, reset  clock and synchronous active-high reset
//   btn_n       raw button pins, low = pressed
//   bus         iomem slave port (registers at addr[7:0], block at addr[31:24])
//   btn_state   debounced pressed state
//   irq         registered level interrupt
// Registers: 0x00 STATE RO, 0x04 PRESS W1C, 0x08 RELEASE W1C,
//            0x0C IRQ_EN RW ([NBTN-1:0] press, [NBTN+7:8] release),
//            0x10 PRESS_CNT RO, cleared by a write to it.
module icemem_button_capture
    import icemem_button_capture_pkg::*;
#(
    parameter int         NBTN            = 4,
    parameter int         DEBOUNCE_CYCLES = 12000,
    parameter logic [7:0] BASE_SEL        = BASE_SEL_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NBTN-1:0]          btn_n,
    icemem_button_capture_if.slave   bus,
    output logic [NBTN-1:0]          btn_state,
    output logic                     irq
);

    logic [NBTN-1:0]  state_w;
    logic [NBTN-1:0]  press_p;
    logic [NBTN-1:0]  release_p;

    logic [NBTN-1:0]  press_reg;
    logic [NBTN-1:0]  release_reg;
    logic [NBTN-1:0]  en_press_reg;
    logic [NBTN-1:0]  en_release_reg;
    logic [CNT_W-1:0] press_cnt_reg;
    logic             ready_reg;
    logic [31:0]      rdata_reg;
    logic             irq_reg;

    logic             fire;
    logic             wr_en;
    logic [7:0]       off;
    logic [31:0]      rd_value;
    logic [NBTN-1:0]  clr_press;
    logic [NBTN-1:0]  clr_release;
    logic             unused_bits;

    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk          (clk),
                .reset        (reset),
                .btn_n        (btn_n[gi]),
                .state        (state_w[gi]),
                .press_pulse  (press_p[gi]),
                .release_pulse(release_p[gi])
            );
        end
    endgenerate

    // A request is accepted only while no completion is pending, so a master
    // holding iomem_valid sees exactly one ready pulse per access.
    assign fire  = bus.iomem_valid && !ready_reg && (bus.iomem_addr[31:24] == BASE_SEL);
    assign wr_en = fire && (bus.iomem_wstrb != 4'h0);
    assign off   = bus.iomem_addr[7:0];

    assign clr_press   = (wr_en && off == ADDR_PRESS && bus.iomem_wstrb[0])
                         ? bus.iomem_wdata[NBTN-1:0] : '0;
    assign clr_release = (wr_en && off == ADDR_RELEASE && bus.iomem_wstrb[0])
                         ? bus.iomem_wdata[NBTN-1:0] : '0;

    // Address bits above the register offset (below the select byte), the
    // upper strobes and the upper data byte carry no meaning here.
    assign unused_bits = &{1'b0, bus.iomem_addr[23:8], bus.iomem_wstrb[3:2],
                           bus.iomem_wdata};

    always_comb begin
        rd_value = '0;
        case (off)
            ADDR_STATE:     rd_value[NBTN-1:0] = state_w;
            ADDR_PRESS:     rd_value[NBTN-1:0] = press_reg;
            ADDR_RELEASE:   rd_value[NBTN-1:0] = release_reg;
            ADDR_IRQ_EN: begin
                rd_value[NBTN-1:0]  = en_press_reg;
                rd_value[NBTN+7:8]  = en_release_reg;
            end
            ADDR_PRESS_CNT: rd_value[CNT_W-1:0] = press_cnt_reg;
            default:        rd_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press_reg      <= '0;
            release_reg    <= '0;
            en_press_reg   <= '0;
            en_release_reg <= '0;
            press_cnt_reg  <= '0;
            ready_reg      <= 1'b0;
            rdata_reg      <= '0;
            irq_reg        <= 1'b0;
        end else begin
            ready_reg <= fire;
            rdata_reg <= fire ? rd_value : 32'h0;

            // OR-ing the new events after the clear lets a same-cycle event win.
            press_reg   <= (press_reg & ~clr_press) | press_p;
            release_reg <= (release_reg & ~clr_release) | release_p;

            if (wr_en && off == ADDR_IRQ_EN) begin
                if (bus.iomem_wstrb[0]) en_press_reg   <= bus.iomem_wdata[NBTN-1:0];
                if (bus.iomem_wstrb[1]) en_release_reg <= bus.iomem_wdata[NBTN+7:8];
            end

            // A clearing write beats a simultaneous press event.
            if (wr_en && off == ADDR_PRESS_CNT) begin
                press_cnt_reg <= '0;
            end else begin
                press_cnt_reg <= press_cnt_reg + CNT_W'(popcount8(8'(press_p)));
            end

            irq_reg <= (|(press_reg & en_press_reg)) | (|(release_reg & en_release_reg));
        end
    end

    assign bus.iomem_ready = ready_reg;
    assign bus.iomem_rdata = rdata_reg;
    assign btn_state       = state_w;
    assign irq             = irq_reg;

endmodule

// File: tb/tb_icemem_button_capture.sv
// Self-checking bench for icemem_button_capture (NBTN=4, DEBOUNCE_CYCLES=8).
// Read expectations are pushed to a scoreboard queue when a test issues its
// reads and popped as each read completes.
module tb_icemem_button_capture;
    import icemem_button_capture_pkg::*;

    localparam int NBTN = 4;
    localparam int DEB  = 8;

    localparam logic [31:0] A_STATE   = 32'h0800_0000;
    localparam logic [31:0] A_PRESS   = 32'h0800_0004;
    localparam logic [31:0] A_RELEASE = 32'h0800_0008;
    localparam logic [31:0] A_IRQ_EN  = 32'h0800_000C;
    localparam logic [31:0] A_CNT     = 32'h0800_0010;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NBTN-1:0] btn_n = '1;
    logic [NBTN-1:0] btn_state;
    logic            irq;

    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic [31:0] exp_q[$];

    icemem_button_capture_if bus();

    icemem_button_capture #(
        .NBTN(NBTN),
        .DEBOUNCE_CYCLES(DEB),
        .BASE_SEL(8'h08)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_n(btn_n),
        .bus(bus),
        .btn_state(btn_state),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // All drives and samples happen 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic got);
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_wdata = 32'h0;
        bus.iomem_valid = 1'b1;
        got  = 1'b0;
        data = 32'h0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1);
            if (bus.iomem_ready === 1'b1) begin
                got  = 1'b1;
                data = bus.iomem_rdata;
            end
        end
        bus.iomem_valid = 1'b0;
        $display("read  addr=%08h ready=%0d rdata=%08h", addr, got, data);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] wstrb,
                             input logic [31:0] wdata, output logic got);
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = wstrb;
        bus.iomem_wdata = wdata;
        bus.iomem_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1);
            if (bus.iomem_ready === 1'b1) got = 1'b1;
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        $display("write addr=%08h wstrb=%h wdata=%08h ready=%0d", addr, wstrb, wdata, got);
    endtask

    task automatic test_reset();
        logic [31:0] ra[5];
        logic [31:0] data, e;
        logic        got;
        reset = 1'b1;
        btn_n = '1;
        bus.iomem_valid = 1'b0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_wdata = 32'h0;
        step(3);
        checks++;
        if (btn_state !== 4'h0 || irq !== 1'b0 || bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: btn_state=%h irq=%b ready=%b rdata=%08h, required all 0",
                     btn_state, irq, bus.iomem_ready, bus.iomem_rdata);
        end
        reset = 1'b0;
        step(4);
        ra = '{A_STATE, A_PRESS, A_RELEASE, A_IRQ_EN, A_CNT};
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 5; i++) begin
            bus_read(ra[i], data, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || data !== e) begin
                errors++;
                $display("FAIL reset_regs[%0d]: ready=%0d rdata=%08h, required %08h", i, got, data, e);
            end
        end
    endtask

    task automatic test_press();
        logic [31:0] ra[6];
        logic [31:0] data, e;
        logic        got;
        btn_n[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == DEB + 1) begin
                checks++;
                if (btn_state[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL press_early: btn_state[0]=%b at %0d cycles, required 0", btn_state[0], k);
                end
            end
            if (k == DEB + 2) begin
                checks++;
                if (btn_state[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL press_latency: btn_state[0]=%b at %0d cycles, required 1", btn_state[0], k);
                end
            end
        end
        exp_cnt++;
        btn_n[0] = 1'b1;
        step(DEB + 4);
        ra = '{A_PRESS, A_CNT, A_RELEASE, A_STATE, A_PRESS, A_RELEASE};
        exp_q.push_back(32'h1);
        exp_q.push_back(32'(exp_cnt));
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_read(ra[i], data, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || data !== e) begin
                errors++;
                $display("FAIL press_regs[%0d]: ready=%0d rdata=%08h, required %08h", i, got, data, e);
            end
        end
        bus_write(A_PRESS, 4'h1, 32'h1, got);
        bus_write(A_RELEASE, 4'h1, 32'h1, got);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int i = 4; i < 6; i++) begin
            bus_read(ra[i], data, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || data !== e) begin
                errors++;
                $display("FAIL press_w1c[%0d]: ready=%0d rdata=%08h, required %08h", i, got, data, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] ra[3];
        logic [31:0] data, e;
        logic        got;
        btn_n[1] = 1'b0;
        step(5);
        btn_n[1] = 1'b1;
        step(15);
        checks++;
        if (btn_state !== 4'h0) begin
            errors++;
            $display("FAIL glitch_state: btn_state=%h, required 0", btn_state);
        end
        ra = '{A_STATE, A_PRESS, A_RELEASE};
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            bus_read(ra[i], data, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || data !== e) begin
                errors++;
                $display("FAIL glitch_regs[%0d]: ready=%0d rdata=%08h, required %08h", i, got, data, e);
            end
        end
    endtask

    task automatic test_irq();
        logic [31:0] data, e;
        logic        got;
        bus_write(A_IRQ_EN, 4'h3, 32'h0000_0001, got);
        exp_q.push_back(32'h1);
        bus_read(A_IRQ_EN, data, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || data !== e) begin
            errors++;
            $display("FAIL irq_en_read: ready=%0d rdata=%08h, required %08h", got, data, e);
        end
        btn_n[0] = 1'b0;
        for (int k = 1; k <= DEB + 3; k++) begin
            step(1);
            if (k == DEB + 2) begin
                checks++;
                if (btn_state[0] !== 1'b1 || irq !== 1'b0) begin
                    errors++;
                    $display("FAIL irq_flag_cycle: btn_state[0]=%b irq=%b, required 1 and 0", btn_state[0], irq);
                end
            end
            if (k == DEB + 3) begin
                checks++;
                if (irq !== 1'b1) begin
                    errors++;
                    $display("FAIL irq_rise: irq=%b, required 1", irq);
                end
            end
        end
        exp_cnt++;
        bus_write(A_PRESS, 4'h1, 32'h1, got);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold: irq=%b on ready cycle, required 1", irq);
        end
        step(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq=%b, required 0", irq);
        end
        btn_n[0] = 1'b1;
        step(DEB + 4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_release_masked: irq=%b, required 0", irq);
        end
        bus_write(A_RELEASE, 4'h1, 32'h1, got);
        bus_write(A_IRQ_EN, 4'h3, 32'h0, got);
    endtask

    task automatic test_bus_decode();
        logic [31:0] ra[3];
        logic [31:0] data, e;
        logic        got, seen;
        exp_q.push_back(32'h0);
        bus_read(32'h0800_0014, data, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || data !== e) begin
            errors++;
            $display("FAIL unmapped_read: ready=%0d rdata=%08h, required ready 1 rdata %08h", got, data, e);
        end
        step(1);
        checks++;
        if (bus.iomem_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_width: ready=%b one cycle after pulse, required 0", bus.iomem_ready);
        end
        bus.iomem_addr  = 32'h0300_0000;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (bus.iomem_ready !== 1'b0) seen = 1'b1;
        end
        bus.iomem_valid = 1'b0;
        $display("read  addr=03000000 held 10 cycles ready_seen=%0d", seen);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL unselected_read: ready_seen=%0d, required 0", seen);
        end
        bus_write(32'h0300_0010, 4'hF, 32'hFFFF_FFFF, got);
        checks++;
        if (got !== 1'b0) begin
            errors++;
            $display("FAIL unselected_write: ready=%0d, required 0", got);
        end
        bus_write(32'h0800_0018, 4'hF, 32'hFFFF_FFFF, got);
        bus_write(A_IRQ_EN, 4'h2, 32'h0000_FFFF, got);
        bus_write(A_IRQ_EN, 4'hC, 32'hFFFF_FFFF, got);
        exp_q.push_back(32'h0000_0F00);
        exp_q.push_back(32'(exp_cnt));
        ra = '{A_IRQ_EN, A_CNT, A_IRQ_EN};
        for (int i = 0; i < 2; i++) begin
            bus_read(ra[i], data, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || data !== e) begin
                errors++;
                $display("FAIL strobe_regs[%0d]: ready=%0d rdata=%08h, required %08h", i, got, data, e);
            end
        end
        bus_write(A_IRQ_EN, 4'h1, 32'h0000_FF0F, got);
        exp_q.push_back(32'h0000_0F0F);
        bus_read(ra[2], data, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || data !== e) begin
            errors++;
            $display("FAIL strobe_byte0: ready=%0d rdata=%08h, required %08h", got, data, e);
        end
        bus_write(A_IRQ_EN, 4'h3, 32'h0, got);
    endtask

    task automatic test_w1c_race();
        logic [31:0] data, e;
        logic        got;
        btn_n[2] = 1'b0;
        step(DEB + 1);
        // Time the write so its accepting edge is the debounce edge.
        bus.iomem_addr  = A_PRESS;
        bus.iomem_wstrb = 4'h1;
        bus.iomem_wdata = 32'h4;
        bus.iomem_valid = 1'b1;
        step(1);
        bus.iomem_valid = 1'b0;
        $display("write addr=%08h wstrb=1 wdata=00000004 ready=%0d (race with press)", A_PRESS, bus.iomem_ready);
        checks++;
        if (bus.iomem_ready !== 1'b1 || btn_state[2] !== 1'b1) begin
            errors++;
            $display("FAIL race_align: ready=%b btn_state[2]=%b, required 1 and 1", bus.iomem_ready, btn_state[2]);
        end
        exp_cnt++;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'(exp_cnt));
        bus_read(A_PRESS, data, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || data !== e) begin
            errors++;
            $display("FAIL race_press_flag: ready=%0d rdata=%08h, required %08h", got, data, e);
        end
        bus_read(A_CNT, data, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || data !== e) begin
            errors++;
            $display("FAIL race_press_cnt: ready=%0d rdata=%08h, required %08h", got, data, e);
        end
        btn_n[2] = 1'b1;
        step(DEB + 4);
        bus_write(A_PRESS, 4'h1, 32'h4, got);
        bus_write(A_RELEASE, 4'h1, 32'h4, got);
        btn_n[2] = 1'b0;
        step(DEB + 1);
        bus.iomem_addr  = A_CNT;
        bus.iomem_wstrb = 4'h3;
        bus.iomem_wdata = 32'h0;
        bus.iomem_valid = 1'b1;
        step(1);
        bus.iomem_valid = 1'b0;
        $display("write addr=%08h wstrb=3 wdata=00000000 ready=%0d (race with press)", A_CNT, bus.iomem_ready);
        exp_cnt = 0;
        exp_q.push_back(32'(exp_cnt));
        bus_read(A_CNT, data, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || data !== e) begin
            errors++;
            $display("FAIL cnt_clear_race: ready=%0d rdata=%08h, required %08h", got, data, e);
        end
        btn_n[2] = 1'b1;
        step(DEB + 4);
        bus_write(A_PRESS, 4'h1, 32'h4, got);
        bus_write(A_RELEASE, 4'h1, 32'h4, got);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra[5];
        logic [31:0] data, e;
        logic        got;
        bus_write(A_IRQ_EN, 4'h3, 32'h0000_0305, got);
        ra = '{A_IRQ_EN, A_STATE, A_PRESS, A_RELEASE, A_CNT};
        exp_q.push_back(32'h0000_0305);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'(exp_cnt));
        // No idle cycle between reads: the next request is raised while ready is high.
        for (int i = 0; i < 5; i++) begin
            bus_read(ra[i], data, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || data !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: ready=%0d rdata=%08h, required %08h", i, got, data, e);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] ra[6];
        logic [31:0] data, e;
        logic        got;
        bus_write(A_IRQ_EN, 4'h3, 32'h0000_0F0F, got);
        btn_n[3] = 1'b0;
        step(7);
        reset = 1'b1;
        step(2);
        checks++;
        if (btn_state !== 4'h0 || irq !== 1'b0 || bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: btn_state=%h irq=%b ready=%b rdata=%08h, required all 0",
                     btn_state, irq, bus.iomem_ready, bus.iomem_rdata);
        end
        reset = 1'b0;
        exp_cnt = 0;
        step(30);
        checks++;
        if (btn_state !== 4'h0) begin
            errors++;
            $display("FAIL held_through_reset: btn_state=%h, required 0", btn_state);
        end
        ra = '{A_PRESS, A_CNT, A_IRQ_EN, A_STATE, A_PRESS, A_CNT};
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_read(ra[i], data, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || data !== e) begin
                errors++;
                $display("FAIL held_regs[%0d]: ready=%0d rdata=%08h, required %08h", i, got, data, e);
            end
        end
        btn_n[3] = 1'b1;
        step(5);
        btn_n[3] = 1'b0;
        step(DEB + 4);
        checks++;
        if (btn_state !== 4'h8) begin
            errors++;
            $display("FAIL repress_state: btn_state=%h, required 8", btn_state);
        end
        exp_cnt++;
        exp_q.push_back(32'h8);
        exp_q.push_back(32'(exp_cnt));
        for (int i = 4; i < 6; i++) begin
            bus_read(ra[i], data, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || data !== e) begin
                errors++;
                $display("FAIL repress_regs[%0d]: ready=%0d rdata=%08h, required %08h", i, got, data, e);
            end
        end
        btn_n[3] = 1'b1;
        step(DEB + 4);
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_irq();
        test_bus_decode();
        test_w1c_race();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
